tdc_fifo_param: RTL and testbench
=================================

Name: tdc_fifo_param

Overview:
Parametrised synchronous FIFO for TDC timestamp words. It is the next generation of the fixed 48-bit, 4-deep timestamp buffer, and sits between the TDC event encoder and the readout/serialiser. Width, depth, read mode and watermark thresholds are set by parameters. It adds watermarks, an occupancy output, sticky overflow/underflow flags, a dropped-word counter and pass-through writes when full.

Parameters:
DATA_W, 48, word width in bits (timestamp + channel tag)
ADDR_W, 2, address width; depth DEPTH = 2**ADDR_W (legal 1..10)
FWFT, 0, 0 = standard read (data one cycle after rd_en), 1 = first-word-fall-through
AF_THRESH, DEPTH-1, almost_full asserted when level >= AF_THRESH
AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH
CNT_W, 16, width of the dropped-word counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
wr_en  in  1  write request
din  in  DATA_W  write data
rd_en  in  1  read request (pop)
dout  out  DATA_W  read data
dout_valid  out  1  FWFT=0: one-cycle pulse, dout updated; FWFT=1: equals !empty
empty  out  1  level == 0
full  out  1  level == DEPTH
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  ADDR_W+1  stored-word count, 0..DEPTH
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was attempted while empty
drop_cnt  out  CNT_W  count of dropped writes, saturating at all-ones
clr_flags  in  1  synchronous clear of overflow, underflow and drop_cnt

Behaviour:
- Reset (async, any time, including mid-burst): wr_ptr = rd_ptr = level = 0; empty = 1; almost_empty = 1; full = almost_full = 0; overflow = underflow = 0; drop_cnt = 0; dout = 0; dout_valid = 0. Memory contents are not reset and are unobservable after reset.
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_acc). When full, a simultaneous accepted read lets the write in.
- When empty with wr_en & rd_en in the same cycle, the read is rejected and the write is accepted. This counts as an underflow event.
- Pointers are ADDR_W bits, increment on accept, and wrap modulo DEPTH.
- Memory write on wr_acc at wr_ptr.
- level: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
- All status outputs are registered and computed from the next-state level, so they reflect the update in the cycle after the accepting edge.
- FWFT=0: on rd_acc, dout <= mem[rd_ptr] at the edge and dout_valid = 1 for that cycle. Otherwise dout holds and dout_valid = 0. Read latency is 1 clk.
- FWFT=1: dout = mem[rd_ptr] (asynchronous memory read) and is valid whenever !empty. rd_acc advances to the next word. A word written into an empty FIFO appears on dout the cycle after the write.
- overflow is set on wr_en & !wr_acc.
- drop_cnt increments on the same condition and saturates at 2**CNT_W-1.
- underflow is set on rd_en & empty.
- clr_flags clears all three. A same-cycle new event has priority: the flag stays 1 and drop_cnt loads 1.
- Parameter checks at elaboration (error): AE_THRESH < AF_THRESH <= DEPTH; ADDR_W >= 1.

Decomposition:
- Package tdc_fifo_pkg: default DATA_W = 48, the timestamp word type, and a function for level-to-flag thresholds.
- One sub-module, tdc_fifo_mem: simple dual-port RAM, DEPTH x DATA_W, synchronous write, with a read port that is registered or asynchronous according to FWFT.
- Pointer, level and flag logic stay in the top module.

Test Plan:
1. Reset, then write 0x000000000001..0x000000000004 (DEPTH = 4) -> full = 1 after the 4th edge, level = 4, almost_full = 1 from level 3. Read 4 (FWFT=0) -> dout 1, 2, 3, 4, each 1 clk after rd_en; empty = 1 at end.
2. Full FIFO: wr_en without rd_en for 3 cycles -> overflow = 1, drop_cnt = 3, contents unchanged. Then wr_en & rd_en -> level stays 4 and the new word is read last.
3. Empty FIFO: wr_en & rd_en with din = 0xABC -> underflow = 1, level = 1, no dout_valid. Next read returns 0xABC.
4. Wrap: 10 interleaved write/read pairs at level 2 -> output order is preserved across pointer wrap and level stays 2.
5. FWFT=1, ADDR_W = 4: write 0x55 -> dout = 0x55 and dout_valid = 1 the next cycle with no rd_en. clr_flags the same cycle as an overflow -> overflow = 1, drop_cnt = 1.
6. Assert rst mid-burst (level = 3) asynchronously between edges -> all outputs take reset values immediately. The first write after release reads back correctly.

Source files
------------

// File: rtl/tdc_fifo_pkg.sv
// Shared types and helpers for the parametrised TDC timestamp FIFO.
// The level-to-flag function is shared so all status flags derive from one rule set.
package tdc_fifo_pkg;

   localparam int TS_W = 48;

   typedef logic [TS_W-1:0] ts_word_t;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   function automatic fifo_flags_t level_flags(input int lvl, input int depth,
                                               input int af_thresh, input int ae_thresh);
      fifo_flags_t f;
      f.empty        = (lvl == 0);
      f.full         = (lvl == depth);
      f.almost_full  = (lvl >= af_thresh);
      f.almost_empty = (lvl <= ae_thresh);
      return f;
   endfunction

endpackage

// File: rtl/tdc_fifo_mem.sv
// Simple dual-port RAM for the timestamp FIFO: synchronous write, read port either
// registered (standard mode) or combinational (first-word-fall-through mode).
module tdc_fifo_mem #(
   parameter int DATA_W = 48,
   parameter int ADDR_W = 2,
   parameter int FWFT   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   generate
      if (FWFT != 0) begin : g_async_rd
         logic w_unused;
         assign w_unused  = rst | i_rd_en;
         assign o_rd_data = r_mem[i_rd_addr];
      end else begin : g_sync_rd
         // Read-before-write: a same-address write returns the old word, which is
         // what a read of a full FIFO with a simultaneous write must see.
         logic [DATA_W-1:0] r_rd_data;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)          r_rd_data <= '0;
            else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
         end
         assign o_rd_data = r_rd_data;
      end
   endgenerate

endmodule

// File: rtl/tdc_fifo_param.sv
// Parametrised synchronous FIFO between the TDC event encoder and the readout.
// Adds watermarks, occupancy, sticky overflow/underflow and a saturating drop counter.
module tdc_fifo_param
   import tdc_fifo_pkg::*;
#(
   parameter int DATA_W    = TS_W,
   parameter int ADDR_W    = 2,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = (1 << ADDR_W) - 1,
   parameter int AE_THRESH = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              underflow,
   output logic [CNT_W-1:0]  drop_cnt,
   input  logic              clr_flags
);

   localparam int                DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   LVL_ONE = 1;
   localparam logic [CNT_W-1:0]  CNT_ONE = 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   generate
      if (ADDR_W < 1 || ADDR_W > 10) begin : g_bad_addr_w
         $error("tdc_fifo_param: ADDR_W must be in 1..10");
      end
      if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
         $error("tdc_fifo_param: need AE_THRESH < AF_THRESH <= DEPTH");
      end
   endgenerate

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_level;
   logic              r_empty;
   logic              r_full;
   logic              r_almost_full;
   logic              r_almost_empty;
   logic              r_overflow;
   logic              r_underflow;
   logic [CNT_W-1:0]  r_drop_cnt;
   logic              r_dout_valid;

   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_drop;
   logic              w_under;
   logic [ADDR_W:0]   w_level_nxt;
   fifo_flags_t       w_flags;
   logic [DATA_W-1:0] w_mem_rd;

   // Handshake: a write is taken when there is room or a read frees a slot in the
   // same cycle; a read is taken only when a stored word exists. No backpressure
   // is returned - refused writes are counted, refused reads are flagged.
   always_comb begin
      w_rd_acc    = rd_en & ~r_empty;
      w_wr_acc    = wr_en & (~r_full | w_rd_acc);
      w_drop      = wr_en & ~w_wr_acc;
      w_under     = rd_en & r_empty;
      w_level_nxt = r_level;
      if (w_wr_acc && !w_rd_acc)      w_level_nxt = r_level + LVL_ONE;
      else if (w_rd_acc && !w_wr_acc) w_level_nxt = r_level - LVL_ONE;
      w_flags = level_flags(int'(w_level_nxt), DEPTH, AF_THRESH, AE_THRESH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_level        <= '0;
         r_empty        <= 1'b1;
         r_full         <= 1'b0;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
         r_drop_cnt     <= '0;
         r_dout_valid   <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_level        <= w_level_nxt;
         r_empty        <= w_flags.empty;
         r_full         <= w_flags.full;
         r_almost_full  <= w_flags.almost_full;
         r_almost_empty <= w_flags.almost_empty;
         r_dout_valid   <= w_rd_acc;

         // A new event in the clearing cycle wins over the clear.
         if (w_drop)         r_overflow <= 1'b1;
         else if (clr_flags) r_overflow <= 1'b0;

         if (w_under)        r_underflow <= 1'b1;
         else if (clr_flags) r_underflow <= 1'b0;

         if (w_drop) begin
            if (clr_flags)                 r_drop_cnt <= CNT_ONE;
            else if (r_drop_cnt != CNT_MAX) r_drop_cnt <= r_drop_cnt + CNT_ONE;
         end else if (clr_flags) begin
            r_drop_cnt <= '0;
         end
      end
   end

   tdc_fifo_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .FWFT   (FWFT)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (din),
      .i_rd_en   (w_rd_acc),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_mem_rd)
   );

   generate
      if (FWFT != 0) begin : g_fwft_out
         // Unwritten RAM is never shown: dout reads as zero while empty.
         logic w_unused_valid;
         assign w_unused_valid = r_dout_valid;
         assign dout       = r_empty ? '0 : w_mem_rd;
         assign dout_valid = ~r_empty;
      end else begin : g_std_out
         assign dout       = w_mem_rd;
         assign dout_valid = r_dout_valid;
      end
   endgenerate

   assign empty        = r_empty;
   assign full         = r_full;
   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
   assign level        = r_level;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;
   assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_tdc_fifo_param.sv
// Testbench for tdc_fifo_param: a standard-read 4-deep instance and a FWFT 16-deep
// instance share one stimulus stream and are checked against queue-based models.
module tb_tdc_fifo_param;

   localparam int W = 48;
   localparam int DEPTH_M   [2] = '{4, 16};
   localparam int AF_M      [2] = '{3, 15};
   localparam int AE_M      [2] = '{1, 1};
   localparam int CNT_MAX_M [2] = '{15, 65535};
   localparam int FWFT_M    [2] = '{0, 1};

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_en;
   logic         rd_en;
   logic         clr_flags;
   logic [W-1:0] din;

   logic [W-1:0] a_dout, b_dout;
   logic         a_dout_valid, a_empty, a_full, a_almost_full, a_almost_empty;
   logic         b_dout_valid, b_empty, b_full, b_almost_full, b_almost_empty;
   logic [2:0]   a_level;
   logic [4:0]   b_level;
   logic         a_overflow, a_underflow, b_overflow, b_underflow;
   logic [3:0]   a_drop_cnt;
   logic [15:0]  b_drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   tdc_fifo_param #(
      .DATA_W(W), .ADDR_W(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1), .CNT_W(4)
   ) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(a_dout), .dout_valid(a_dout_valid), .empty(a_empty), .full(a_full),
      .almost_full(a_almost_full), .almost_empty(a_almost_empty), .level(a_level),
      .overflow(a_overflow), .underflow(a_underflow), .drop_cnt(a_drop_cnt),
      .clr_flags(clr_flags)
   );

   tdc_fifo_param #(
      .DATA_W(W), .ADDR_W(4), .FWFT(1), .AF_THRESH(15), .AE_THRESH(1), .CNT_W(16)
   ) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(b_dout), .dout_valid(b_dout_valid), .empty(b_empty), .full(b_full),
      .almost_full(b_almost_full), .almost_empty(b_almost_empty), .level(b_level),
      .overflow(b_overflow), .underflow(b_underflow), .drop_cnt(b_drop_cnt),
      .clr_flags(clr_flags)
   );

   // ---------------- scoreboard / reference model ----------------
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   logic [W-1:0] m_dout [2];
   logic         m_val  [2];
   logic         m_ovf  [2];
   logic         m_unf  [2];
   int           m_cnt  [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int q_size(input int id);
      return (id == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [W-1:0] q_front(input int id);
      return (id == 0) ? exp_q0[0] : exp_q1[0];
   endfunction

   task automatic q_push(input int id, input logic [W-1:0] d);
      if (id == 0) exp_q0.push_back(d);
      else         exp_q1.push_back(d);
   endtask

   task automatic q_pop(input int id, output logic [W-1:0] d);
      if (id == 0) d = exp_q0.pop_front();
      else         d = exp_q1.pop_front();
   endtask

   task automatic model_reset();
      exp_q0.delete();
      exp_q1.delete();
      for (int i = 0; i < 2; i++) begin
         m_dout[i] = '0;
         m_val[i]  = 1'b0;
         m_ovf[i]  = 1'b0;
         m_unf[i]  = 1'b0;
         m_cnt[i]  = 0;
      end
   endtask

   // Applies one clock edge's worth of FIFO rules to model id.
   task automatic model_step(input int id);
      int           sz;
      bit           ra, wa, dr, un;
      logic [W-1:0] w;
      sz = q_size(id);
      ra = rd_en && (sz > 0);
      wa = wr_en && ((sz < DEPTH_M[id]) || ra);
      dr = wr_en && !wa;
      un = rd_en && (sz == 0);
      m_val[id] = 1'b0;
      if (ra) begin
         q_pop(id, w);
         if (FWFT_M[id] == 0) begin
            m_dout[id] = w;
            m_val[id]  = 1'b1;
         end
      end
      if (wa) q_push(id, din);
      if (dr)             m_ovf[id] = 1'b1;
      else if (clr_flags) m_ovf[id] = 1'b0;
      if (un)             m_unf[id] = 1'b1;
      else if (clr_flags) m_unf[id] = 1'b0;
      if (dr)             m_cnt[id] = clr_flags ? 1 : ((m_cnt[id] < CNT_MAX_M[id]) ? m_cnt[id] + 1 : m_cnt[id]);
      else if (clr_flags) m_cnt[id] = 0;
   endtask

   task automatic compare_one(input int id, input logic [W-1:0] dout, input logic valid,
                              input logic emp, input logic ful, input logic af, input logic ae,
                              input logic [63:0] lvl, input logic ovf, input logic unf,
                              input logic [63:0] cnt);
      int    sz;
      string p;
      sz = q_size(id);
      p  = (id == 0) ? "a" : "b";
      check({p, ".level"}, lvl, 64'(sz));
      check({p, ".empty"}, emp, sz == 0);
      check({p, ".full"}, ful, sz == DEPTH_M[id]);
      check({p, ".almost_full"}, af, sz >= AF_M[id]);
      check({p, ".almost_empty"}, ae, sz <= AE_M[id]);
      check({p, ".overflow"}, ovf, m_ovf[id]);
      check({p, ".underflow"}, unf, m_unf[id]);
      check({p, ".drop_cnt"}, cnt, 64'(m_cnt[id]));
      if (FWFT_M[id] != 0) begin
         check({p, ".dout_valid"}, valid, sz > 0);
         if (sz > 0) check({p, ".dout"}, dout, q_front(id));
      end else begin
         check({p, ".dout_valid"}, valid, m_val[id]);
         check({p, ".dout"}, dout, m_dout[id]);
      end
   endtask

   task automatic compare_all();
      compare_one(0, a_dout, a_dout_valid, a_empty, a_full, a_almost_full, a_almost_empty,
                  64'(a_level), a_overflow, a_underflow, 64'(a_drop_cnt));
      compare_one(1, b_dout, b_dout_valid, b_empty, b_full, b_almost_full, b_almost_empty,
                  64'(b_level), b_overflow, b_underflow, 64'(b_drop_cnt));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
      model_step(0);
      model_step(1);
      compare_all();
   endtask

   task automatic drive(input logic w, input logic r, input logic [W-1:0] d, input logic c);
      wr_en     = w;
      rd_en     = r;
      din       = d;
      clr_flags = c;
      step();
   endtask

   task automatic drain();
      while (q_size(0) + q_size(1) > 0) drive(1'b0, 1'b1, '0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b1);
   endtask

   // Reset is raised between edges; outputs must clear before any further edge.
   task automatic async_reset();
      #3 rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      check("rst.a_dout", a_dout, '0);
      check("rst.b_dout", b_dout, '0);
      check("rst.a_empty", a_empty, 1'b1);
      wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; din = '0;
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] rnd;
      int          pw, pr;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; din = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      check("rst.a_almost_empty", a_almost_empty, 1'b1);
      rst = 1'b0;

      // 1: fill to full, then read back in order
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b0, W'(i), 1'b0);
         if (i == 3) check("t1.af_at_3", a_almost_full, 1'b1);
      end
      check("t1.full", a_full, 1'b1);
      check("t1.level", a_level, 3'd4);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, 1'b1, '0, 1'b0);
         check("t1.dout", a_dout, W'(i));
         check("t1.valid", a_dout_valid, 1'b1);
      end
      check("t1.empty", a_empty, 1'b1);
      drain();

      // 2: overflow while full, then write-through with a read
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, W'(16'h10 + i), 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, W'(16'h100 + i), 1'b0);
      check("t2.overflow", a_overflow, 1'b1);
      check("t2.drop_cnt", a_drop_cnt, 4'd3);
      drive(1'b1, 1'b1, W'(16'h200), 1'b0);
      check("t2.level", a_level, 3'd4);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, '0, 1'b0);
      check("t2.last", a_dout, W'(16'h200));
      drain();

      // 3: simultaneous write and read on an empty FIFO
      drive(1'b1, 1'b1, W'(12'hABC), 1'b0);
      check("t3.underflow", a_underflow, 1'b1);
      check("t3.level", a_level, 3'd1);
      check("t3.no_valid", a_dout_valid, 1'b0);
      check("t3.b_fwft", b_dout, W'(12'hABC));
      drive(1'b0, 1'b1, '0, 1'b0);
      check("t3.dout", a_dout, W'(12'hABC));
      drain();

      // 4: pointer wrap at constant level 2
      drive(1'b1, 1'b0, W'(16'h300), 1'b0);
      drive(1'b1, 1'b0, W'(16'h301), 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, W'(16'h302 + i), 1'b0);
         check("t4.level", a_level, 3'd2);
         check("t4.dout", a_dout, W'(16'h300 + i));
      end
      drain();

      // 5: FWFT instance shows first word without a read; clear loses to a new drop
      drive(1'b1, 1'b0, W'(8'h55), 1'b0);
      check("t5.dout", b_dout, W'(8'h55));
      check("t5.valid", b_dout_valid, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b0);
      check("t5.hold", b_dout, W'(8'h55));
      for (int i = 1; i < 16; i++) drive(1'b1, 1'b0, W'(16'h500 + i), 1'b0);
      check("t5.b_full", b_full, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b1, 1'b0, W'(8'h77), 1'b1);
      check("t5.overflow", b_overflow, 1'b1);
      check("t5.drop_cnt", b_drop_cnt, 16'd1);
      // drop counter saturation on the narrow counter
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, W'(i), 1'b0);
      check("t5.sat", a_drop_cnt, 4'hF);
      drain();

      // 6: asynchronous reset mid-burst
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, W'(16'h600 + i), 1'b0);
      check("t6.pre_level", a_level, 3'd3);
      async_reset();
      check("t6.level", a_level, 3'd0);
      drive(1'b1, 1'b0, W'(16'h9876), 1'b0);
      check("t6.b_dout", b_dout, W'(16'h9876));
      drive(1'b0, 1'b1, '0, 1'b0);
      check("t6.a_dout", a_dout, W'(16'h9876));
      drain();

      // randomized traffic with shifting write/read pressure
      for (int seg = 0; seg < 12; seg++) begin
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int i = 0; i < 50; i++) begin
            rnd = {$urandom(), $urandom()};
            drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, rnd[W-1:0],
                  $urandom_range(0, 31) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
